// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the counter-width helper.
package serial_subtractor_4bit_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // A one-bit operand still needs a one-bit counter, so clamp $clog2 at 1.
  function automatic int cntWidth(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_4bit_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out bout.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: D = A - B - B_in computed LSB first, one bit per clock,
// through a single full-subtractor cell; result and borrow are held until the next completion.
module serial_subtractor_4bit
  import serial_subtractor_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B_out
);

  localparam int             CW   = cntWidth(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] d_sr_q;
  logic [WIDTH-1:0] d_sr_d;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] D_q;
  logic             B_out_q;
  logic             busy_q;
  logic             done_q;
  logic             diff;
  logic             bo;

  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (brw_q),
    .d    (diff),
    .bout (bo)
  );

  // The difference bit enters at the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts.
  assign d_sr_d = {diff, d_sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      D_q     <= '0;
      B_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= A;
            b_sr_q  <= B;
            brw_q   <= B_in;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          d_sr_q <= d_sr_d;
          brw_q  <= bo;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            D_q     <= d_sr_d;
            B_out_q <= bo;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign D     = D_q;
  assign B_out = B_out_q;

endmodule
